// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MIPS data-memory responder and its storage array.
package mips_mem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

    localparam int WORD_BYTES = 4;

    // Word-aligned and inside the array; callers zero-extend the byte address to 64 bits.
    function automatic logic addr_ok(input logic [63:0] addr, input int unsigned depth);
        return (addr[1:0] == 2'b00) && (addr[63:2] < 62'(depth));
    endfunction

endpackage

// File: rtl/mips_dmem_array.sv
// Word-organised storage: one synchronous byte-masked write port, one registered read port.
module mips_dmem_array
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [WORD_BYTES-1:0] be,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [31:0]           wdata,
    input  logic [IDX_W-1:0]      raddr,
    output logic [31:0]           rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // NOTE: storage has no reset; clearing a RAM needs a sweep and maps poorly onto memory macros.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/mips_dmem_responder.sv
// Memory side of the MIPS load/store port: one request at a time, fixed LATENCY, held response.
// Optional macro DMEM_BYTE_STROBE_EN adds the req_be byte-enable port for partial stores.
module mips_dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
    input  logic [WORD_BYTES-1:0] req_be,
`endif
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    dmem_state_t           state;
    logic [3:0]            cnt;
    logic                  lat_write;
    logic [ADDR_W-1:0]     lat_addr;
    logic [DATA_W-1:0]     lat_wdata;
    logic                  resp_is_load;
    logic                  cur_write;
    logic [ADDR_W-1:0]     cur_addr;
    logic [DATA_W-1:0]     cur_wdata;
    logic [WORD_BYTES-1:0] cur_be;
    logic                  cur_ok;
    logic                  accept;
    logic                  enter_resp;
    logic [31:0]           rd_data;
`ifdef DMEM_BYTE_STROBE_EN
    logic [WORD_BYTES-1:0] lat_be;
`endif

    assign accept     = (state == IDLE) && req_valid && req_ready;
    assign enter_resp = (accept && (LATENCY == 1)) || ((state == WAIT) && (cnt == 4'd1));

    // With LATENCY==1 the response is entered on the accept edge, so the live request must be used.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cur_write = lat_write;
        cur_addr  = lat_addr;
        cur_wdata = lat_wdata;
        cur_be    = '1;
`ifdef DMEM_BYTE_STROBE_EN
        cur_be    = lat_be;
`endif
        if (state == IDLE) begin
            cur_write = req_write;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
            cur_be    = req_be;
`endif
        end
    end

    assign cur_ok = addr_ok(64'(cur_addr), DEPTH_WORDS);

    mips_dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (enter_resp && !rst && cur_write && cur_ok),
        .be    (cur_be),
        .waddr (cur_addr[2 +: IDX_W]),
        .wdata (cur_wdata),
        .raddr (cur_addr[2 +: IDX_W]),
        .rdata (rd_data)
    );

    // Request latch is pure datapath, qualified by the FSM, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
            lat_be    <= req_be;
`endif
        end
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values in any order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            req_ready    <= 1'b0;
            resp_valid   <= 1'b0;
            resp_err     <= 1'b0;
            resp_is_load <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt       <= 4'(LATENCY - 1);
                        req_ready <= 1'b0;
                        state     <= (LATENCY == 1) ? RESP : WAIT;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        state        <= IDLE;
                        req_ready    <= 1'b1;
                        resp_valid   <= 1'b0;
                        resp_err     <= 1'b0;
                        resp_is_load <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            if (enter_resp) begin
                resp_valid   <= 1'b1;
                resp_err     <= !cur_ok;
                resp_is_load <= !cur_write && cur_ok;
            end
        end
    end

    // The read register stays on the latched word throughout RESP, so the data is frozen.
    assign resp_rdata = (resp_valid && resp_is_load) ? DATA_W'(rd_data) : '0;

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Directed bench: LATENCY=2 instance for reset/load/store/error/stall, LATENCY=1 instance for throughput.
module tb_mips_dmem_responder;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    int          checks   = 0;
    int          failures = 0;

    logic        req_valid_a, req_ready_a, req_write_a, resp_valid_a, resp_ready_a, resp_err_a;
    logic [31:0] req_addr_a, req_wdata_a, resp_rdata_a;
    logic        req_valid_b, req_ready_b, req_write_b, resp_valid_b, resp_ready_b, resp_err_b;
    logic [31:0] req_addr_b, req_wdata_b, resp_rdata_b;
`ifdef DMEM_BYTE_STROBE_EN
    logic [3:0]  req_be_a;
    logic [3:0]  req_be_b;
`endif

    always #5 clk = ~clk;

    mips_dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid_a),
        .req_ready  (req_ready_a),
        .req_write  (req_write_a),
        .req_addr   (req_addr_a),
        .req_wdata  (req_wdata_a),
`ifdef DMEM_BYTE_STROBE_EN
        .req_be     (req_be_a),
`endif
        .resp_valid (resp_valid_a),
        .resp_ready (resp_ready_a),
        .resp_rdata (resp_rdata_a),
        .resp_err   (resp_err_a)
    );

    mips_dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid_b),
        .req_ready  (req_ready_b),
        .req_write  (req_write_b),
        .req_addr   (req_addr_b),
        .req_wdata  (req_wdata_b),
`ifdef DMEM_BYTE_STROBE_EN
        .req_be     (req_be_b),
`endif
        .resp_valid (resp_valid_b),
        .resp_ready (resp_ready_b),
        .resp_rdata (resp_rdata_b),
        .resp_err   (resp_err_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle; all sampling and driving happens here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready_a(input string tag);
        int n = 0;
        while (!req_ready_a && n < 20) begin
            step();
            n++;
        end
        check({tag, "_ready"}, 32'(req_ready_a), 32'd1);
    endtask

    // One full transaction on the LATENCY=2 instance with its expected response.
    task automatic txn_a(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
        int lat = 0;
        wait_ready_a(tag);
        req_valid_a = 1'b1;
        req_write_a = wr;
        req_addr_a  = addr;
        req_wdata_a = wdata;
        step();
        req_valid_a = 1'b0;
        check({tag, "_busy"}, 32'(req_ready_a), 32'd0);
        while (!resp_valid_a && lat < 20) begin
            step();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd1);
        check({tag, "_rdata"}, resp_rdata_a, exp_rdata);
        check({tag, "_err"}, 32'(resp_err_a), 32'(exp_err));
        resp_ready_a = 1'b1;
        step();
        resp_ready_a = 1'b0;
        check({tag, "_done"}, 32'(resp_valid_a), 32'd0);
        check({tag, "_rearm"}, 32'(req_ready_a), 32'd1);
    endtask

    logic        b_wr   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] b_addr [4] = '{32'h100, 32'h104, 32'h100, 32'h104};
    logic [31:0] b_data [4] = '{32'hA1, 32'hA2, 32'h0, 32'h0};
    logic [31:0] b_exp  [4] = '{32'h0, 32'h0, 32'hA1, 32'hA2};

    initial begin
        int n;
        rst          = 1'b1;
        req_valid_a  = 1'b0; req_write_a = 1'b0; req_addr_a = '0; req_wdata_a = '0; resp_ready_a = 1'b0;
        req_valid_b  = 1'b0; req_write_b = 1'b0; req_addr_b = '0; req_wdata_b = '0; resp_ready_b = 1'b0;
`ifdef DMEM_BYTE_STROBE_EN
        req_be_a = 4'hF;
        req_be_b = 4'hF;
`endif
        repeat (2) step();
        check("rst_req_ready", 32'(req_ready_a), 32'd0);
        check("rst_resp_valid", 32'(resp_valid_a), 32'd0);
        check("rst_rdata", resp_rdata_a, 32'd0);
        check("rst_err", 32'(resp_err_a), 32'd0);
        rst = 1'b0;
        step();
        check("post_rst_ready_a", 32'(req_ready_a), 32'd1);
        check("post_rst_ready_b", 32'(req_ready_b), 32'd1);

        // Reset in the middle of WAIT drops a store before it commits.
        txn_a("prior_st", 1'b1, 32'h10, 32'h11112222, 32'h0, 1'b0);
        wait_ready_a("mid_rst");
        req_valid_a = 1'b1; req_write_a = 1'b1; req_addr_a = 32'h10; req_wdata_a = 32'hDEADBEEF;
        step();
        req_valid_a = 1'b0;
        rst = 1'b1;
        step();
        check("mid_rst_no_resp1", 32'(resp_valid_a), 32'd0);
        step();
        check("mid_rst_no_resp2", 32'(resp_valid_a), 32'd0);
        check("mid_rst_ready_low", 32'(req_ready_a), 32'd0);
        rst = 1'b0;
        step();
        check("mid_rst_ready_back", 32'(req_ready_a), 32'd1);
        txn_a("mid_rst_ld", 1'b0, 32'h10, 32'h0, 32'h11112222, 1'b0);

        // Basic store/load and read-after-write.
        txn_a("st20", 1'b1, 32'h20, 32'h12345678, 32'h0, 1'b0);
        txn_a("ld20", 1'b0, 32'h20, 32'h0, 32'h12345678, 1'b0);
        txn_a("st40", 1'b1, 32'h40, 32'h01010101, 32'h0, 1'b0);
        txn_a("st00", 1'b1, 32'h0, 32'h0BADF00D, 32'h0, 1'b0);

        // Misaligned and out-of-range accesses must error and leave the array alone.
        txn_a("ld22_mis", 1'b0, 32'h22, 32'h0, 32'h0, 1'b1);
        txn_a("st23_mis", 1'b1, 32'h23, 32'hFFFFFFFF, 32'h0, 1'b1);
        txn_a("st_oor", 1'b1, 32'(4 * DEPTH), 32'hCAFEF00D, 32'h0, 1'b1);
        txn_a("ld_oor", 1'b0, 32'(4 * DEPTH), 32'h0, 32'h0, 1'b1);
        txn_a("ld20_kept", 1'b0, 32'h20, 32'h0, 32'h12345678, 1'b0);
        txn_a("ld00_kept", 1'b0, 32'h0, 32'h0, 32'h0BADF00D, 1'b0);

        // Response stall with a competing request held on the input.
        wait_ready_a("stall");
        req_valid_a = 1'b1; req_write_a = 1'b0; req_addr_a = 32'h20;
        step();
        req_write_a = 1'b1; req_addr_a = 32'h40; req_wdata_a = 32'hFFFFFFFF;
        n = 0;
        while (!resp_valid_a && n < 20) begin
            step();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall_valid%0d", i), 32'(resp_valid_a), 32'd1);
            check($sformatf("stall_rdata%0d", i), resp_rdata_a, 32'h12345678);
            check($sformatf("stall_ready%0d", i), 32'(req_ready_a), 32'd0);
            step();
        end
        req_valid_a  = 1'b0;
        resp_ready_a = 1'b1;
        step();
        resp_ready_a = 1'b0;
        check("stall_done", 32'(resp_valid_a), 32'd0);
        txn_a("ld40_kept", 1'b0, 32'h40, 32'h0, 32'h01010101, 1'b0);

`ifdef DMEM_BYTE_STROBE_EN
        txn_a("be_init", 1'b1, 32'h30, 32'hAABBCCDD, 32'h0, 1'b0);
        req_be_a = 4'b0010;
        txn_a("be_st", 1'b1, 32'h30, 32'h00001100, 32'h0, 1'b0);
        req_be_a = 4'b0000;
        txn_a("be_none", 1'b1, 32'h30, 32'h99999999, 32'h0, 1'b0);
        req_be_a = 4'hF;
        txn_a("be_ld", 1'b0, 32'h30, 32'h0, 32'hAABB11DD, 1'b0);
`endif

        // LATENCY=1: accept and response alternate every cycle.
        n = 0;
        while (!req_ready_b && n < 20) begin
            step();
            n++;
        end
        check("b_ready", 32'(req_ready_b), 32'd1);
        resp_ready_b = 1'b1;
        req_valid_b  = 1'b1;
        req_write_b  = b_wr[0]; req_addr_b = b_addr[0]; req_wdata_b = b_data[0];
        for (int k = 0; k < 8; k++) begin
            step();
            if (k % 2 == 0) begin
                check($sformatf("b_valid%0d", k), 32'(resp_valid_b), 32'd1);
                check($sformatf("b_busy%0d", k), 32'(req_ready_b), 32'd0);
                check($sformatf("b_rdata%0d", k), resp_rdata_b, b_exp[k/2]);
                check($sformatf("b_err%0d", k), 32'(resp_err_b), 32'd0);
                if (k / 2 < 3) begin
                    req_write_b = b_wr[k/2 + 1]; req_addr_b = b_addr[k/2 + 1]; req_wdata_b = b_data[k/2 + 1];
                end else begin
                    req_valid_b = 1'b0;
                end
            end else begin
                check($sformatf("b_idle%0d", k), 32'(resp_valid_b), 32'd0);
                check($sformatf("b_ready%0d", k), 32'(req_ready_b), 32'd1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
